// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// dmem_port_arbiter: shares a 1024x32 word memory between two byte-addressed requesters.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed A-over-B priority.
module dmem_port_arbiter #(
  parameter int AW  = 20,
  parameter int BAW = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           a_req,
  input  logic           a_we,
  input  logic [1:0]     a_size,
  input  logic           a_sgn,
  input  logic [BAW-1:0] a_addr,
  input  logic [31:0]    a_wdata,
  output logic           a_gnt,
  output logic           a_rvalid,
  output logic [31:0]    a_rdata,
  output logic           a_err,
  input  logic           b_req,
  input  logic           b_we,
  input  logic [1:0]     b_size,
  input  logic           b_sgn,
  input  logic [BAW-1:0] b_addr,
  input  logic [31:0]    b_wdata,
  output logic           b_gnt,
  output logic           b_rvalid,
  output logic [31:0]    b_rdata,
  output logic           b_err,
  output logic           mem_str,
  output logic           mem_ld,
  output logic [3:0]     mem_sel,
  output logic [AW-1:0]  mem_addr,
  output logic [31:0]    mem_wdata,
  input  logic [31:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t        state;
  logic          port_q;      // 0 = A, 1 = B
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          sgn_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          can_accept;
  logic          pick_b;
  logic          in_access;
  logic          in_resp;
  logic [3:0]    sel;
  logic          err;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic [31:0]   ext;

  // Byte-address bits above the word range alias and are deliberately dropped.
  logic unused_ok;
  assign unused_ok = &{1'b0, a_addr[BAW-1:AW+2], b_addr[BAW-1:AW+2]};

  assign can_accept = (state != ACCESS) && !clr;
  assign in_access  = (state == ACCESS);
  assign in_resp    = (state == RESP);

`ifdef DMEM_ARB_RR_EN
  logic last_b;
  // On a tie the port that was not granted last wins.
  assign pick_b = b_req && (!a_req || !last_b);
`else
  assign pick_b = b_req && !a_req;
`endif

  assign a_gnt = can_accept && a_req && !pick_b;
  assign b_gnt = can_accept && pick_b;

  always_comb begin
    sel = 4'b0000;
    err = 1'b0;
    case (size_q)
      2'd0: sel = 4'b0001 << addr_q[1:0];
      2'd1: begin
        sel = addr_q[1] ? 4'b1100 : 4'b0011;
        err = addr_q[0];
      end
      2'd2: begin
        sel = 4'b1111;
        err = |addr_q[1:0];
      end
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    lane8  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane16 = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    ext = {{24{sgn_q & lane8[7]}}, lane8};
      2'd1:    ext = {{16{sgn_q & lane16[15]}}, lane16};
      default: ext = mem_rdata;
    endcase
  end

  assign mem_str   = in_access && we_q && !err;
  assign mem_ld    = in_access && !we_q && !err;
  assign mem_sel   = (in_access && !err) ? sel : 4'b0000;
  assign mem_addr  = in_access ? addr_q[AW+1:2] : '0;
  assign mem_wdata = in_access ? wdata_q : 32'd0;

  assign a_rvalid = in_resp && !port_q;
  assign b_rvalid = in_resp && port_q;
  assign a_rdata  = a_rvalid ? rdata_q : 32'd0;
  assign b_rdata  = b_rvalid ? rdata_q : 32'd0;
  assign a_err    = a_rvalid && err_q;
  assign b_err    = b_rvalid && err_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      port_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_b  <= 1'b1;
`endif
    end else begin
      case (state)
        ACCESS: begin
          rdata_q <= (we_q || err) ? 32'd0 : ext;
          err_q   <= err;
          state   <= RESP;
        end
        default: begin
          if (a_gnt || b_gnt) begin
            port_q  <= b_gnt;
            addr_q  <= b_gnt ? b_addr[AW+1:0] : a_addr[AW+1:0];
            size_q  <= b_gnt ? b_size : a_size;
            we_q    <= b_gnt ? b_we : a_we;
            sgn_q   <= b_gnt ? b_sgn : a_sgn;
            wdata_q <= b_gnt ? b_wdata : a_wdata;
`ifdef DMEM_ARB_RR_EN
            last_b  <= b_gnt;
`endif
            state   <= ACCESS;
          end else begin
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// tb_dmem_port_arbiter: directed self-checking bench with a behavioural 1024x32 memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        a_req = 0, a_we = 0, a_sgn = 0;
  logic [1:0]  a_size = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        b_req = 0, b_we = 0, b_sgn = 0;
  logic [1:0]  b_size = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_str, mem_ld;
  logic [3:0]  mem_sel;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  int str_cnt = 0;
  int ld_cnt = 0;
  int rv_cnt = 0;

  dmem_port_arbiter #(.AW(20), .BAW(32)) dut (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_sgn(a_sgn), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_sgn(b_sgn), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_str(mem_str), .mem_ld(mem_ld), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_ld ? mem[mem_addr[9:0]] : 32'd0;

  // Memory takes the low byte/half of wdata for sub-word lane selects.
  always @(posedge clk) begin
    if (mem_str) begin
      case (mem_sel)
        4'b1111: mem[mem_addr[9:0]]        <= mem_wdata;
        4'b0011: mem[mem_addr[9:0]][15:0]  <= mem_wdata[15:0];
        4'b1100: mem[mem_addr[9:0]][31:16] <= mem_wdata[15:0];
        4'b0001: mem[mem_addr[9:0]][7:0]   <= mem_wdata[7:0];
        4'b0010: mem[mem_addr[9:0]][15:8]  <= mem_wdata[7:0];
        4'b0100: mem[mem_addr[9:0]][23:16] <= mem_wdata[7:0];
        4'b1000: mem[mem_addr[9:0]][31:24] <= mem_wdata[7:0];
        default: ;
      endcase
    end
    if (mem_str) str_cnt <= str_cnt + 1;
    if (mem_ld) ld_cnt <= ld_cnt + 1;
    if (a_rvalid || b_rvalid) rv_cnt <= rv_cnt + 1;
  end

  // One access on one port; lat = cycles from gnt to rvalid, -1 on timeout.
  task automatic access(input bit pb, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic str, output logic ld, output logic [3:0] sel,
                        output logic [19:0] maddr);
    int n;
    bit got;
    rdata = 0; err = 0; lat = -1; str = 0; ld = 0; sel = 0; maddr = 0;
    @(negedge clk);
    if (pb) begin
      b_req = 1; b_we = we; b_size = size; b_sgn = sgn; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1; a_we = we; a_size = size; a_sgn = sgn; a_addr = addr; a_wdata = wdata;
    end
    got = 0;
    n = 0;
    while (!got && n < 10) begin
      #1;
      if (pb ? b_gnt : a_gnt) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    a_req = 0;
    b_req = 0;
    if (!got) return;
    #1;
    str = mem_str; ld = mem_ld; sel = mem_sel; maddr = mem_addr;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
      #1;
      if (pb ? b_rvalid : a_rvalid) begin
        lat = n;
        rdata = pb ? b_rdata : a_rdata;
        err = pb ? b_err : a_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_req = 1;
    #1;
    checks++;
    if (a_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt: got %b want 0", a_gnt);
    end
    checks++;
    if ({a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
         mem_str, mem_ld, mem_sel, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero during clr (str=%b ld=%b sel=%b)",
               mem_str, mem_ld, mem_sel);
    end
    a_req = 0;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er, st, ld; logic [3:0] sl; logic [19:0] ma; int lat;
    access(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (st !== 1'b1 || sl !== 4'b1111 || ma !== 20'd4) begin
      failures++;
      $display("FAIL word_store_bus: str=%b sel=%b addr=%0d want 1 1111 4", st, sl, ma);
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_store_mem: got %h want deadbeef", mem[4]);
    end
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      failures++;
      $display("FAIL word_store_resp: rdata=%h err=%b want 0 0", rd, er);
    end
    access(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL word_load_latency: got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || ld !== 1'b1 || st !== 1'b0) begin
      failures++;
      $display("FAIL word_load: rdata=%h err=%b ld=%b str=%b want deadbeef 0 1 0", rd, er, ld, st);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er, st, ld; logic [3:0] sl; logic [19:0] ma; int lat;
    access(0, 1, 2'd2, 0, 32'h10, 32'h80FF0001, rd, er, lat, st, ld, sl, ma);
    access(0, 0, 2'd0, 1, 32'h13, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (sl !== 4'b1000 || rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      failures++;
      $display("FAIL byte_load_sgn: sel=%b rdata=%h err=%b want 1000 ffffff80 0", sl, rd, er);
    end
    access(0, 0, 2'd0, 0, 32'h13, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (rd !== 32'h00000080) begin
      failures++;
      $display("FAIL byte_load_zero: got %h want 00000080", rd);
    end
    access(1, 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (rd !== 32'h80FF0001 || lat !== 2) begin
      failures++;
      $display("FAIL port_b_load: rdata=%h lat=%0d want 80ff0001 2", rd, lat);
    end
    access(0, 0, 2'd2, 0, 32'h0040_0010, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (ma !== 20'd4 || rd !== 32'h80FF0001) begin
      failures++;
      $display("FAIL alias_load: addr=%0d rdata=%h want 4 80ff0001", ma, rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er, st, ld; logic [3:0] sl; logic [19:0] ma; int lat;
    access(0, 1, 2'd1, 0, 32'h22, 32'h0000A5C3, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (sl !== 4'b1100 || ma !== 20'd8 || mem[8][31:16] !== 16'hA5C3) begin
      failures++;
      $display("FAIL half_store: sel=%b addr=%0d hi=%h want 1100 8 a5c3", sl, ma, mem[8][31:16]);
    end
    access(0, 0, 2'd1, 1, 32'h22, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (rd !== 32'hFFFFA5C3) begin
      failures++;
      $display("FAIL half_load_sgn: got %h want ffffa5c3", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, st, ld; logic [3:0] sl; logic [19:0] ma; int lat;
    logic [31:0] m2;
    int s0, l0;
    m2 = mem[2];
    s0 = str_cnt;
    l0 = ld_cnt;
    access(0, 0, 2'd2, 0, 32'h06, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
      failures++;
      $display("FAIL err_word_misalign: err=%b rdata=%h lat=%0d want 1 0 2", er, rd, lat);
    end
    access(0, 0, 2'd1, 0, 32'h03, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL err_half_misalign: err=%b rdata=%h want 1 0", er, rd);
    end
    access(0, 1, 2'd3, 0, 32'h08, 32'h11111111, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL err_size3: err=%b rdata=%h want 1 0", er, rd);
    end
    checks++;
    if (str_cnt != s0 || ld_cnt != l0 || mem[2] !== m2) begin
      failures++;
      $display("FAIL err_no_strobe: str=%0d ld=%0d want 0 0, mem2 changed=%b",
               str_cnt - s0, ld_cnt - l0, mem[2] !== m2);
    end
  endtask

  task automatic test_priority();
    int ng, last_i;
    logic [5:0] pat;
    logic [5:0] want;
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    ng = 0;
    last_i = -1;
    pat = 0;
    a_we = 0; a_size = 2'd2; a_addr = 32'h10; a_sgn = 0;
    b_we = 0; b_size = 2'd2; b_addr = 32'h10; b_sgn = 0;
    a_req = 1;
    b_req = 1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (a_gnt || b_gnt) begin
        if (ng < 6) pat[ng] = b_gnt;
        ng++;
        last_i = i;
      end
    end
    @(negedge clk);
    a_req = 0;
    b_req = 0;
    repeat (2) @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    want = 6'b101010;
`else
    want = 6'b000000;
`endif
    checks++;
    if (ng !== 6 || last_i !== 10) begin
      failures++;
      $display("FAIL prio_throughput: gnts=%0d last_cycle=%0d want 6 10", ng, last_i);
    end
    checks++;
    if (pat !== want) begin
      failures++;
      $display("FAIL prio_pattern: got %b want %b (bit k = 1 means B won slot k)", pat, want);
    end
  endtask

  task automatic test_clr_access();
    logic [31:0] rd; logic er, st, ld; logic [3:0] sl; logic [19:0] ma; int lat;
    logic [31:0] m16;
    int s0, r0;
    m16 = mem[16];
    s0 = str_cnt;
    r0 = rv_cnt;
    @(negedge clk);
    a_req = 1; a_we = 1; a_size = 2'd2; a_sgn = 0; a_addr = 32'h40; a_wdata = 32'h12345678;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL clr_pre_gnt: got %b want 1", a_gnt);
    end
    @(negedge clk);
    a_req = 0;
    clr = 1;
    #1;
    checks++;
    if ({a_gnt, a_rvalid, a_rdata, a_err, b_gnt, b_rvalid, b_rdata, b_err,
         mem_str, mem_ld, mem_sel, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL clr_outputs: output nonzero in clr (str=%b sel=%b)", mem_str, mem_sel);
    end
    repeat (2) @(negedge clk);
    clr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (str_cnt != s0 || rv_cnt != r0 || mem[16] !== m16) begin
      failures++;
      $display("FAIL clr_dropped: stores=%0d rvalids=%0d want 0 0", str_cnt - s0, rv_cnt - r0);
    end
    access(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, st, ld, sl, ma);
    checks++;
    if (rd !== 32'h80FF0001 || lat !== 2 || er !== 1'b0) begin
      failures++;
      $display("FAIL clr_recover: rdata=%h lat=%0d err=%b want 80ff0001 2 0", rd, lat, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_priority();
    test_clr_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (word-addressed, 1024 x 32, byte-lane `sel`, `str` write strobe, combinational `ld`-gated read) between two byte-addressed requesters.
  - Port A: CPU MEM stage.
  - Port B: debug/display reader, or a loader.
- Arbitrates between the ports and converts byte address plus size into word address and lane select.
- Sequences each access through a small FSM; registers the sign- or zero-extended load result and returns it with a completion handshake.

Parameters:
- AW, 20, word-address width driven to memory (`mem_addr`).
- BAW, 32, requester byte-address width; bits [AW+1:2] form the word address, upper bits ignored.

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- a_req  in  1  port A request, level; held until a_gnt
- a_we  in  1  1 = store, 0 = load
- a_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- a_sgn  in  1  load sign-extend (1) / zero-extend (0)
- a_addr  in  BAW  byte address
- a_wdata  in  32  store data, right-justified
- a_gnt  out  1  one-cycle pulse: request accepted
- a_rvalid  out  1  one-cycle pulse: access complete
- a_rdata  out  32  extended load data, valid with a_rvalid
- a_err  out  1  misaligned or reserved size, valid with a_rvalid
- b_req, b_we, b_size, b_sgn, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: identical set for port B
- mem_str  out  1  memory store enable
- mem_ld  out  1  memory load enable
- mem_sel  out  4  byte-lane select
- mem_addr  out  AW  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  memory read data (combinational)

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (clr high, asynchronous):
  - FSM goes to IDLE; all outputs 0; latched request cleared.
  - In-flight access dropped: no rvalid, no store.
  - mem_str and mem_ld are 0 throughout clr.
- Accept (IDLE or RESP, any req high):
  - Winner chosen by priority; its gnt pulses combinationally in that cycle.
  - addr, size, we, sgn, wdata and port id latched at the edge; next state ACCESS.
  - Requester may drop req after gnt.
- Priority: fixed, A over B.
- No request in RESP: next state IDLE.
- Decode (combinational from latched fields):
  - size 0: sel = 4'b0001 << addr[1:0].
  - size 1: sel = addr[1] ? 4'b1100 : 4'b0011; addr[0] must be 0.
  - size 2: sel = 4'b1111; addr[1:0] must be 00.
  - size 3, or alignment violated: err = 1.
- ACCESS (exactly 1 cycle):
  - Drives mem_addr = addr[AW+1:2] and mem_sel; mem_wdata = latched wdata unshifted (memory takes the low byte/half for sub-word lanes).
  - mem_str = we & ~err; the store commits at the ACCESS->RESP edge.
  - mem_ld = ~we & ~err. At the same edge, rdata register captures the selected lane of mem_rdata, shifted to bit 0, extended to 32 bits per size/sgn.
  - On error: no strobes; rdata = 0.
  - Always moves to RESP.
- RESP (1 cycle): granted port's rvalid = 1 with rdata/err; other port's rvalid = 0. Stores return rdata = 0.
- Timing:
  - Latency: gnt cycle N -> rvalid cycle N+2.
  - Back-to-back throughput: one access per 2 cycles (accept in RESP).
  - Outside ACCESS: mem_str = mem_ld = 0 and mem_sel = 0.
- Simultaneous events:
  - Both req in the same accept cycle: only one gnt; loser keeps req and is served in the next accept slot unless it loses priority again.
  - req asserted during ACCESS: ignored until RESP.
- Wrap-around: byte address bits above AW+1 are ignored, so addresses alias modulo 4·2^AW.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin priority.
  - 1-bit last-grant register, reset to B, so A wins the first tie.
  - On a tie, the port not granted last wins.
  - Updated on every gnt.
- Undefined: fixed priority, A always wins; B can starve under continuous A traffic.

Test Plan:
- A stores word 0xDEADBEEF at byte 0x10, then loads word at 0x10 -> mem write at mem_addr 4 with sel 1111; load rvalid 2 cycles after gnt, rdata 0xDEADBEEF, err 0.
- A loads byte 0x13 with sgn = 1, then sgn = 0 (word = 0x80FF0001) -> sel 1000; rdata 0xFFFFFF80, then 0x00000080.
- A stores half 0xA5C3 at 0x22, then loads half at 0x22 with sgn = 1 -> sel 1100, mem[8][31:16] = 0xA5C3; rdata 0xFFFFA5C3.
- A loads word at 0x06 and half at 0x03; A store with size 3 -> each: err 1, rdata 0, mem_str/mem_ld never high, memory unchanged.
- A and B both request continuously for 6 accept slots -> fixed build: six A gnts, zero B; with DMEM_ARB_RR_EN: gnts alternate A, B, A, B, A, B.
- clr pulsed during ACCESS of a store of 0x12345678 -> no rvalid, all outputs 0; FSM IDLE on the first edge after clr falls; new A request granted normally.
